pe_mac_pipe: RTL and testbench



---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_mac_pipe_if.sv | 28 ++
 rtl/pe_mul_pipe.sv | 44 ++++
 rtl/pe_mac_pipe.sv | 83 ++++++++
 tb/tb_pe_mac_pipe.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared helpers for the MAC processing element: parameter legality,
// saturation limits and round-half-up scaling on a 64-bit signed working width.
package pe_pkg;
    typedef logic signed [63:0] wide_t;

    function automatic bit params_ok(int in_len, int acc_len, int out_len, int frac, int mul_stages);
        return acc_len >= 2 * in_len && acc_len <= 62 && out_len <= acc_len &&
               frac >= 0 && frac < acc_len && mul_stages >= 1 && mul_stages <= 3;
    endfunction

    function automatic wide_t sat_max(int out_len, bit sgn);
        return sgn ? (wide_t'(1) <<< (out_len - 1)) - wide_t'(1) : (wide_t'(1) <<< out_len) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(int out_len, bit sgn);
        return sgn ? -(wide_t'(1) <<< (out_len - 1)) : wide_t'(0);
    endfunction

    // Arithmetic shift plus the last bit shifted out gives round-half-up for either sign.
    function automatic wide_t round_shift(wide_t v, int frac);
        return frac == 0 ? v : (v >>> frac) + ((v >>> (frac - 1)) & wide_t'(1));
    endfunction
endpackage

// File: rtl/pe_mac_pipe_if.sv
// pe_mac_pipe_if: operand, pass-through and result-chain signals of one PE.
interface pe_mac_pipe_if #(
    parameter int IN_LEN  = 8,
    parameter int OUT_LEN = 16
);
    logic               cal_en;
    logic               cal_done;
    logic [IN_LEN-1:0]  westin;
    logic [IN_LEN-1:0]  northin;
    logic               din_val;
    logic [OUT_LEN-1:0] din;
    logic               n_cal_en;
    logic               n_cal_done;
    logic [IN_LEN-1:0]  eastout;
    logic [IN_LEN-1:0]  southout;
    logic               dout_val;
    logic [OUT_LEN-1:0] dout;
    logic               ovf;

    modport master (
        output cal_en, cal_done, westin, northin, din_val, din,
        input  n_cal_en, n_cal_done, eastout, southout, dout_val, dout, ovf
    );
    modport slave (
        input  cal_en, cal_done, westin, northin, din_val, din,
        output n_cal_en, n_cal_done, eastout, southout, dout_val, dout, ovf
    );
endinterface

// File: rtl/pe_mul_pipe.sv
// pe_mul_pipe: MUL_STAGES-deep multiplier with a valid/last tag riding alongside.
module pe_mul_pipe #(
    parameter int IN_LEN     = 8,
    parameter int SIGNED     = 1,
    parameter int MUL_STAGES = 1
) (
    input  logic                clk,
    input  logic                sys_rst_n,
    input  logic                en,
    input  logic                last,
    input  logic [IN_LEN-1:0]   a,
    input  logic [IN_LEN-1:0]   b,
    output logic [2*IN_LEN-1:0] p,
    output logic                p_val,
    output logic                p_last
);
    logic [2*IN_LEN-1:0] ea, eb;
    logic [2*IN_LEN-1:0] p_q [MUL_STAGES];
    logic [MUL_STAGES-1:0] v_q, l_q;

    // Low 2*IN_LEN bits of the extended product equal the exact signed or unsigned product.
    assign ea = {{IN_LEN{SIGNED != 0 && a[IN_LEN-1]}}, a};
    assign eb = {{IN_LEN{SIGNED != 0 && b[IN_LEN-1]}}, b};

    always_ff @(posedge clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) p_q[i] <= '0;
            v_q <= '0;
            l_q <= '0;
        end else begin
            p_q[0] <= ea * eb;
            v_q[0] <= en;
            l_q[0] <= en & last;
            for (int i = 1; i < MUL_STAGES; i++) begin
                p_q[i] <= p_q[i-1];
                v_q[i] <= v_q[i-1];
                l_q[i] <= l_q[i-1];
            end
        end

    assign p      = p_q[MUL_STAGES-1];
    assign p_val  = v_q[MUL_STAGES-1];
    assign p_last = l_q[MUL_STAGES-1];
endmodule

// File: rtl/pe_mac_pipe.sv
// pe_mac_pipe: output-stationary systolic MAC PE with pipelined multiply, wide
// accumulator, rounded/saturated result and a one-deep skid on the result chain.
module pe_mac_pipe
    import pe_pkg::*;
#(
    parameter int IN_LEN     = 8,
    parameter int ACC_LEN    = 24,
    parameter int OUT_LEN    = 16,
    parameter int FRAC       = 0,
    parameter int SIGNED     = 1,
    parameter int MUL_STAGES = 1
) (
    input logic          clk,
    input logic          sys_rst_n,
    pe_mac_pipe_if.slave bus
);
    localparam bit    SGN = SIGNED != 0;
    localparam wide_t HI  = sat_max(OUT_LEN, SGN);
    localparam wide_t LO  = sat_min(OUT_LEN, SGN);

    if (!params_ok(IN_LEN, ACC_LEN, OUT_LEN, FRAC, MUL_STAGES)) begin : g_bad_params
        $error("pe_mac_pipe: illegal parameter combination");
    end

    logic [2*IN_LEN-1:0] p;
    logic                p_val, p_last;
    logic [ACC_LEN-1:0]  acc, base, ext_p, sum;
    logic [ACC_LEN:0]    full;
    logic                first, acc_ovf, cur_ovf, sat, own, skid_load, skid_val;
    wide_t               rnd;
    logic [OUT_LEN-1:0]  res, skid;

    pe_mul_pipe #(.IN_LEN(IN_LEN), .SIGNED(SIGNED), .MUL_STAGES(MUL_STAGES)) u_mul (
        .clk(clk), .sys_rst_n(sys_rst_n), .en(bus.cal_en), .last(bus.cal_done),
        .a(bus.westin), .b(bus.northin), .p(p), .p_val(p_val), .p_last(p_last)
    );

    always_comb begin
        base      = first ? '0 : acc;
        ext_p     = {{(ACC_LEN-2*IN_LEN){SGN && p[2*IN_LEN-1]}}, p};
        full      = {1'b0, base} + {1'b0, ext_p};
        sum       = full[ACC_LEN-1:0];
        cur_ovf   = acc_ovf | (SGN ? base[ACC_LEN-1] == ext_p[ACC_LEN-1] && sum[ACC_LEN-1] != base[ACC_LEN-1]
                                   : full[ACC_LEN]);
        rnd       = round_shift({{(64-ACC_LEN){SGN && sum[ACC_LEN-1]}}, sum}, FRAC);
        sat       = rnd > HI || rnd < LO;
        res       = OUT_LEN'(rnd > HI ? HI : rnd < LO ? LO : rnd);
        own       = p_val & p_last;
        skid_load = bus.din_val & !(own & skid_val);
    end

    // A din arriving with an own result while the skid is already full has nowhere to go.
    always_ff @(posedge clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            acc            <= '0;
            first          <= 1'b1;
            acc_ovf        <= 1'b0;
            skid_val       <= 1'b0;
            skid           <= '0;
            bus.n_cal_en   <= 1'b0;
            bus.n_cal_done <= 1'b0;
            bus.eastout    <= '0;
            bus.southout   <= '0;
            bus.dout_val   <= 1'b0;
            bus.dout       <= '0;
            bus.ovf        <= 1'b0;
        end else begin
            bus.n_cal_en   <= bus.cal_en;
            bus.n_cal_done <= bus.cal_done;
            bus.eastout    <= bus.cal_en ? bus.westin : '0;
            bus.southout   <= bus.cal_en ? bus.northin : '0;
            if (p_val) begin
                acc     <= sum;
                first   <= p_last;
                acc_ovf <= cur_ovf & !p_last;
            end
            skid_val <= own ? skid_val | bus.din_val : skid_val & bus.din_val;
            if (skid_load) skid <= bus.din;
            bus.dout_val <= own | skid_val | bus.din_val;
            bus.ovf      <= own & (cur_ovf | sat);
            bus.dout     <= own ? res : skid_val ? skid : bus.din_val ? bus.din : '0;
        end
endmodule

// File: tb/tb_pe_mac_pipe.sv
// tb_pe_mac_pipe: directed vectors driven in parallel into five PE configurations,
// each checked against hand-computed results.
module tb_pe_mac_pipe;
    logic        clk = 1'b0, sys_rst_n = 1'b0;
    logic        cal_en = 1'b0, cal_done = 1'b0, din_val = 1'b0;
    logic [7:0]  westin = '0, northin = '0;
    logic [15:0] din = '0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    pe_mac_pipe_if #(.IN_LEN(8), .OUT_LEN(16)) if_u (), if_s1 (), if_s3 (), if_fr ();
    pe_mac_pipe_if #(.IN_LEN(8), .OUT_LEN(8))  if_o8 ();

    assign if_u.cal_en = cal_en;   assign if_u.cal_done = cal_done;   assign if_u.westin = westin;
    assign if_u.northin = northin; assign if_u.din_val = din_val;     assign if_u.din = din;
    assign if_s1.cal_en = cal_en;  assign if_s1.cal_done = cal_done;  assign if_s1.westin = westin;
    assign if_s1.northin = northin; assign if_s1.din_val = din_val;   assign if_s1.din = din;
    assign if_s3.cal_en = cal_en;  assign if_s3.cal_done = cal_done;  assign if_s3.westin = westin;
    assign if_s3.northin = northin; assign if_s3.din_val = din_val;   assign if_s3.din = din;
    assign if_fr.cal_en = cal_en;  assign if_fr.cal_done = cal_done;  assign if_fr.westin = westin;
    assign if_fr.northin = northin; assign if_fr.din_val = din_val;   assign if_fr.din = din;
    assign if_o8.cal_en = cal_en;  assign if_o8.cal_done = cal_done;  assign if_o8.westin = westin;
    assign if_o8.northin = northin; assign if_o8.din_val = din_val;   assign if_o8.din = din[7:0];

    pe_mac_pipe #(.SIGNED(0))                u_u  (.clk(clk), .sys_rst_n(sys_rst_n), .bus(if_u));
    pe_mac_pipe #(.SIGNED(1))                u_s1 (.clk(clk), .sys_rst_n(sys_rst_n), .bus(if_s1));
    pe_mac_pipe #(.SIGNED(1), .MUL_STAGES(3)) u_s3 (.clk(clk), .sys_rst_n(sys_rst_n), .bus(if_s3));
    pe_mac_pipe #(.SIGNED(1), .FRAC(4))      u_fr (.clk(clk), .sys_rst_n(sys_rst_n), .bus(if_fr));
    pe_mac_pipe #(.SIGNED(1), .OUT_LEN(8))   u_o8 (.clk(clk), .sys_rst_n(sys_rst_n), .bus(if_o8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [7:0] w, input logic [7:0] n, input logic d);
        cal_en = 1'b1; cal_done = d; westin = w; northin = n;
        tick();
        cal_en = 1'b0; cal_done = 1'b0; westin = '0; northin = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        cal_en = 1'b1; westin = 8'h5A; northin = 8'h3C; din_val = 1'b1; din = 16'hBEEF;
        repeat (3) tick();
        chk("rst_dout_val", if_u.dout_val, 0);
        chk("rst_dout", if_u.dout, 0);
        chk("rst_east", if_u.eastout, 0);
        chk("rst_n_cal_en", if_u.n_cal_en, 0);
        cal_en = 1'b0; westin = '0; northin = '0; din_val = 1'b0; din = '0;
        sys_rst_n = 1'b1;
        tick();

        pair(8'd1, 8'd2, 1'b0);
        chk("pass_east", if_u.eastout, 1);
        chk("pass_south", if_u.southout, 2);
        chk("pass_n_cal_en", if_u.n_cal_en, 1);
        pair(8'd3, 8'd4, 1'b0);
        pair(8'd5, 8'd6, 1'b0);
        pair(8'd7, 8'd8, 1'b1);
        chk("pass_n_cal_done", if_u.n_cal_done, 1);
        chk("u_early_val", if_u.dout_val, 0);
        tick();
        chk("u_dot_val", if_u.dout_val, 1);
        chk("u_dot", if_u.dout, 100);
        chk("u_dot_ovf", if_u.ovf, 0);
        tick();
        chk("u_idle_east", if_u.eastout, 0);
        chk("u_idle_val", if_u.dout_val, 0);

        pair(8'hFD, 8'd5, 1'b0);
        pair(8'd4, 8'hFE, 1'b0);
        pair(8'hFF, 8'hFF, 1'b1);
        tick();
        chk("s1_dot", if_s1.dout, 16'hFFEA);
        chk("s1_val", if_s1.dout_val, 1);
        chk("s1_ovf", if_s1.ovf, 0);
        tick();
        chk("s3_early_val", if_s3.dout_val, 0);
        tick();
        chk("s3_val", if_s3.dout_val, 1);
        chk("s3_dot", if_s3.dout, 16'hFFEA);
        repeat (2) tick();

        pair(8'd3, 8'd3, 1'b0);
        pair(8'd1, 8'd2, 1'b1);
        tick();
        chk("fr_round", if_fr.dout, 1);
        chk("fr_ovf", if_fr.ovf, 0);
        chk("s1_eleven", if_s1.dout, 11);
        pair(8'h7F, 8'h7F, 1'b0);
        pair(8'h7F, 8'h7F, 1'b1);
        tick();
        chk("o8_sat_hi", if_o8.dout, 8'h7F);
        chk("o8_sat_hi_ovf", if_o8.ovf, 1);
        chk("s1_nosat", if_s1.dout, 16'h7E02);
        chk("s1_nosat_ovf", if_s1.ovf, 0);
        pair(8'h80, 8'h7F, 1'b1);
        tick();
        chk("o8_sat_lo", if_o8.dout, 8'h80);
        chk("o8_sat_lo_ovf", if_o8.ovf, 1);
        chk("s1_neg", if_s1.dout, 16'hC080);

        for (int i = 0; i < 259; i++) pair(8'hFF, 8'hFF, 1'b0);
        pair(8'd1, 8'd1, 1'b1);
        tick();
        chk("u_acc_wrap", if_u.dout, 16'hFB04);
        chk("u_acc_wrap_ovf", if_u.ovf, 1);
        tick();

        pair(8'd2, 8'd3, 1'b0);
        pair(8'd4, 8'd5, 1'b1);
        pair(8'd1, 8'd1, 1'b0);
        chk("b2b_first", if_u.dout, 26);
        chk("b2b_first_val", if_u.dout_val, 1);
        chk("b2b_first_ovf", if_u.ovf, 0);
        pair(8'd6, 8'd6, 1'b1);
        chk("b2b_gap", if_u.dout_val, 0);
        tick();
        chk("b2b_second", if_u.dout, 37);
        chk("b2b_second_val", if_u.dout_val, 1);
        tick();

        din_val = 1'b1; din = 16'h1234;
        tick();
        din_val = 1'b0;
        chk("fwd_dout", if_u.dout, 16'h1234);
        chk("fwd_ovf", if_u.ovf, 0);
        pair(8'd4, 8'd4, 1'b1);
        din_val = 1'b1; din = 16'h0055;
        tick();
        din = 16'h0066;
        chk("col_own", if_u.dout, 16'h0010);
        chk("col_own_val", if_u.dout_val, 1);
        tick();
        din_val = 1'b0; din = '0;
        chk("col_skid", if_u.dout, 16'h0055);
        chk("col_skid_ovf", if_u.ovf, 0);
        tick();
        chk("col_refill", if_u.dout, 16'h0066);
        chk("col_refill_val", if_u.dout_val, 1);
        tick();
        chk("col_drained_val", if_u.dout_val, 0);
        chk("col_drained", if_u.dout, 0);

        pair(8'd5, 8'd5, 1'b0);
        pair(8'd6, 8'd6, 1'b0);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_east", if_u.eastout, 0);
        chk("mid_rst_n_cal_en", if_u.n_cal_en, 0);
        tick();
        sys_rst_n = 1'b1;
        tick();
        pair(8'd1, 8'd1, 1'b0);
        pair(8'd2, 8'd2, 1'b1);
        tick();
        chk("restart_dot", if_u.dout, 5);
        chk("restart_val", if_u.dout_val, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
